bd_fsk_tx: RTL and testbench

- Transmit side of the BD tone link. Serializes a two-byte frame into a stream of 8-bit DAC codes.
- Each bit occupies a fixed window of clock cycles:
  - bit 1: the output toggles between HI and LO codes at a fast rate (many sign-bit transitions per window).
  - bit 0: the output holds one level for the whole window (no transitions).
- Sits between the BD framing logic (valid/ready source) and the DAC; the bit-7 transition-count receiver on the far end recovers the bytes.

---
 rtl/bd_pkg.sv | 18 +
 rtl/bd_tone_gen.sv | 41 ++++
 rtl/bd_fsk_tx.sv | 110 +++++++++++
 tb/tb_bd_fsk_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bd_pkg.sv
// Shared definitions for the BD tone link (transmitter and receiver).
package bd_pkg;

    typedef logic [15:0] bd_frame_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } bd_tx_state_t;

    localparam int          BD_BIT_CYCLES = 32;
    localparam int          BD_HALF_1     = 2;
    localparam int          BD_GAP_CYCLES = 32;
    localparam logic [7:0]  BD_HI_CODE    = 8'hC0;
    localparam logic [7:0]  BD_LO_CODE    = 8'h40;

endpackage

// File: rtl/bd_tone_gen.sv
// Maps (bit, window cycle) to a DAC level and registers it; bit 1 toggles, bit 0 holds LO.
module bd_tone_gen
    import bd_pkg::*;
#(
    parameter int         BIT_CYCLES = BD_BIT_CYCLES,
    parameter int         HALF_1     = BD_HALF_1,
    parameter logic [7:0] HI_CODE    = BD_HI_CODE,
    parameter logic [7:0] LO_CODE    = BD_LO_CODE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic                          bit_i,
    input  logic [$clog2(BIT_CYCLES)-1:0] cyc_i,
    output logic [7:0]                    dac_o
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic [7:0] dac_d;
    logic [7:0] dac_q;

    // Phase restarts with cyc at every window start, so each bit-1 window begins HI.
    always_comb begin
        dac_d = LO_CODE;
        if (en_i && bit_i && (((cyc_i / CW'(HALF_1)) & CW'(1)) == '0)) begin
            dac_d = HI_CODE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dac_q <= LO_CODE;
        end else begin
            dac_q <= dac_d;
        end
    end

    assign dac_o = dac_q;

endmodule

// File: rtl/bd_fsk_tx.sv
// BD tone-link transmitter: accepts a two-byte frame and sends it LSB first as tone windows.
// state | meaning
// IDLE  | tx_ready high, DAC at LO, waiting for a frame
// SEND  | shifting out 16 bit windows of BIT_CYCLES clocks each
// GAP   | forced LO idle of GAP_CYCLES clocks before accepting again
module bd_fsk_tx
    import bd_pkg::*;
#(
    parameter int         BIT_CYCLES = BD_BIT_CYCLES,
    parameter int         HALF_1     = BD_HALF_1,
    parameter int         GAP_CYCLES = BD_GAP_CYCLES,
    parameter logic [7:0] HI_CODE    = BD_HI_CODE,
    parameter logic [7:0] LO_CODE    = BD_LO_CODE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data_0,
    input  logic [7:0] tx_data_1,
    output logic [7:0] dac_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    bd_tx_state_t  state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    bd_frame_t     sreg_q, sreg_d;
    logic [GW-1:0] gap_q, gap_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_idx_q <= '0;
            sreg_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_idx_q <= bit_idx_d;
            sreg_q    <= sreg_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_idx_d  = bit_idx_q;
        sreg_d     = sreg_q;
        gap_d      = gap_q;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d   = SEND;
                    cyc_d     = '0;
                    bit_idx_d = '0;
                    sreg_d    = {tx_data_1, tx_data_0};
                end
            end
            SEND: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CYC_LAST) begin
                    sreg_d    = sreg_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 4'd15) begin
                        frame_done = 1'b1;
                        gap_d      = GAP_LOAD;
                        state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    // Fed with next-state values so dac_out lines up with the cycle the state is in.
    bd_tone_gen #(
        .BIT_CYCLES (BIT_CYCLES),
        .HALF_1     (HALF_1),
        .HI_CODE    (HI_CODE),
        .LO_CODE    (LO_CODE)
    ) u_tone (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_d == SEND),
        .bit_i (sreg_d[0]),
        .cyc_i (cyc_d),
        .dac_o (dac_out)
    );

endmodule

// File: tb/tb_bd_fsk_tx.sv
// Self-checking bench for bd_fsk_tx: frame table, random frames, reset and back-to-back cases.
module tb_bd_fsk_tx;

    localparam int BITC  = 32;
    localparam int HALF  = 2;
    localparam int GAPC  = 32;
    localparam int SEND_LEN = 16 * BITC;
    localparam int FRAME_LEN = SEND_LEN + GAPC + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data_0 = 8'h00;
    logic [7:0] tx_data_1 = 8'h00;
    logic [7:0] dac_out;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    bit keep_valid = 1'b0;

    bd_fsk_tx #(
        .BIT_CYCLES (BITC),
        .HALF_1     (HALF),
        .GAP_CYCLES (GAPC),
        .HI_CODE    (8'hC0),
        .LO_CODE    (8'h40)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data_0  (tx_data_0),
        .tx_data_1  (tx_data_1),
        .dac_out    (dac_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: {dac, frame_done, tx_ready, busy} in cycle k (1 = first cycle after transfer).
    function automatic logic [10:0] model(input logic [15:0] d, input int k);
        int b;
        int c;
        logic [7:0] lvl;
        if (k <= SEND_LEN) begin
            b = (k - 1) / BITC;
            c = (k - 1) % BITC;
            lvl = (d[b] && ((c / HALF) % 2 == 0)) ? 8'hC0 : 8'h40;
            return {lvl, (k == SEND_LEN), 1'b0, 1'b1};
        end else if (k < FRAME_LEN) begin
            return {8'h40, 1'b0, 1'b0, 1'b1};
        end
        return {8'h40, 1'b0, 1'b1, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame and checks every cycle until tx_ready returns; also acts as the
    // far-end receiver (bit = more than one bit-7 transition inside a window).
    task automatic run_frame(input logic [7:0] d0, input logic [7:0] d1, input bit scramble,
                             output logic [15:0] rx, output int trans, output int win_max,
                             output int fd_cyc, output int rdy_cyc);
        int w;
        int wcnt[16];
        logic prev;
        logic [15:0] d;
        d = {d1, d0};
        rx = '0; trans = 0; win_max = 0; fd_cyc = -1; rdy_cyc = -1;
        foreach (wcnt[i]) wcnt[i] = 0;
        tx_data_0 = d0;
        tx_data_1 = d1;
        tx_valid  = 1'b1;
        w = 0;
        while (!tx_ready && w < 2000) begin
            step();
            w++;
        end
        chk("ready before transfer", {31'd0, tx_ready}, 32'd1);
        if (!tx_ready) return;
        step();
        if (!keep_valid) tx_valid = 1'b0;
        prev = 1'b0;
        for (int k = 1; k <= FRAME_LEN; k++) begin
            chk($sformatf("frame %04h cyc%0d {dac,fd,rdy,busy}", d, k),
                {21'd0, dac_out, frame_done, tx_ready, busy}, {21'd0, model(d, k)});
            if (k <= SEND_LEN) begin
                if (dac_out[7] != prev) begin
                    trans++;
                    if ((k - 1) % BITC != 0) wcnt[(k - 1) / BITC]++;
                end
            end
            if (frame_done && fd_cyc < 0) fd_cyc = k;
            if (tx_ready && rdy_cyc < 0) rdy_cyc = k;
            prev = dac_out[7];
            if (scramble) begin
                tx_data_0 = 8'($urandom);
                tx_data_1 = 8'($urandom);
            end
            if (k < FRAME_LEN) step();
        end
        for (int i = 0; i < 16; i++) begin
            rx[i] = (wcnt[i] > 1);
            if (wcnt[i] > win_max) win_max = wcnt[i];
        end
    endtask

    typedef struct {
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [15:0] exp_rx;
        int          exp_trans;
        int          exp_win_max;
    } vec_t;

    initial begin
        vec_t tbl[4];
        logic [15:0] rx;
        int trans, win_max, fd_cyc, rdy_cyc;
        logic [7:0] r0, r1, e0, e1;

        tbl[0] = '{8'hA5, 8'h3C, 16'h3CA5, 128, 15};
        tbl[1] = '{8'hFF, 8'hFF, 16'hFFFF, 256, 15};
        tbl[2] = '{8'h00, 8'h00, 16'h0000,   0,  0};
        tbl[3] = '{8'h01, 8'h80, 16'h8001,  32, 15};

        // Reset held with tx_valid high
        rst = 1'b0;
        tx_valid = 1'b1;
        tx_data_0 = 8'hFF;
        tx_data_1 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset cyc%0d {dac,fd,rdy,busy}", i),
                {21'd0, dac_out, frame_done, tx_ready, busy}, {21'd0, 8'h40, 1'b0, 1'b1, 1'b0});
        end
        tx_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("idle after reset busy", {31'd0, busy}, 32'd0);

        for (int t = 0; t < 4; t++) begin
            run_frame(tbl[t].d0, tbl[t].d1, 1'b0, rx, trans, win_max, fd_cyc, rdy_cyc);
            chk($sformatf("tbl%0d rx", t), {16'd0, rx}, {16'd0, tbl[t].exp_rx});
            chk($sformatf("tbl%0d transitions", t), trans, tbl[t].exp_trans);
            chk($sformatf("tbl%0d window max transitions", t), win_max, tbl[t].exp_win_max);
            chk($sformatf("tbl%0d frame_done cycle", t), fd_cyc, 512);
            chk($sformatf("tbl%0d ready cycle", t), rdy_cyc, 545);
        end

        for (int t = 0; t < 5; t++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            run_frame(r0, r1, 1'b0, rx, trans, win_max, fd_cyc, rdy_cyc);
            chk($sformatf("rand%0d rx", t), {16'd0, rx}, {16'd0, r1, r0});
        end

        // Mid-frame reset during bit 6
        tx_data_0 = 8'hFF;
        tx_data_1 = 8'hFF;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int k = 1; k <= 6 * BITC + 3; k++) begin
            chk($sformatf("abort frame cyc%0d", k),
                {21'd0, dac_out, frame_done, tx_ready, busy}, {21'd0, model(16'hFFFF, k)});
            step();
        end
        rst = 1'b0;
        step();
        chk("abort {dac,fd,rdy,busy}",
            {21'd0, dac_out, frame_done, tx_ready, busy}, {21'd0, 8'h40, 1'b0, 1'b1, 1'b0});
        rst = 1'b1;
        run_frame(8'h5A, 8'hC3, 1'b0, rx, trans, win_max, fd_cyc, rdy_cyc);
        chk("after abort rx", {16'd0, rx}, 32'h0000C35A);
        chk("after abort ready cycle", rdy_cyc, 545);

        // Back-to-back with tx_valid held and data churning during the first frame
        keep_valid = 1'b1;
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        e0 = 8'($urandom);
        e1 = 8'($urandom);
        run_frame(r0, r1, 1'b1, rx, trans, win_max, fd_cyc, rdy_cyc);
        chk("b2b first rx", {16'd0, rx}, {16'd0, r1, r0});
        chk("b2b first ready cycle", rdy_cyc, 545);
        keep_valid = 1'b0;
        run_frame(e0, e1, 1'b0, rx, trans, win_max, fd_cyc, rdy_cyc);
        chk("b2b second rx", {16'd0, rx}, {16'd0, e1, e0});
        chk("b2b second frame_done cycle", fd_cyc, 512);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
